// File: rtl/esm_pkg.sv
// Shared RV32I opcode constants and the per-word control decode used by the ESM fetch front end.
// Decode is opcode-only; funct fields do not influence ALUSrc/RegWrite.

package esm_pkg;

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;

   typedef struct packed {
      logic alu_src;
      logic reg_write;
      logic illegal;
   } decode_t;

   function automatic decode_t decode_opcode(input logic [6:0] opcode);
      decode_t d;
      d = '{alu_src: 1'b0, reg_write: 1'b0, illegal: 1'b0};
      case (opcode)
         OpcOp: begin
            d.reg_write = 1'b1;
         end
         OpcOpImm, OpcLoad, OpcJalr, OpcLui, OpcAuipc: begin
            d.alu_src   = 1'b1;
            d.reg_write = 1'b1;
         end
         OpcStore: begin
            d.alu_src = 1'b1;
         end
         OpcBranch: begin
            d.alu_src   = 1'b0;
            d.reg_write = 1'b0;
         end
         OpcJal: begin
            d.reg_write = 1'b1;
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/esm_fetch_queue.sv
// Synchronous prefetch FIFO holding {pc, instr} entries; clear drops every entry in one cycle.
// A push into a full queue is only accepted when the head is popped on the same edge.

module esm_fetch_queue #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [Width-1:0]         push_data_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   output logic [Width-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CntW'(Depth));
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Depth is a power of two, so pointer overflow is the wrap.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/esm_fetch_decode.sv
// Instruction fetch front end for ESM: credit-limited requests, in-order response capture into a
// prefetch queue, flush/redirect with drop of in-flight words, and combinational head decode.

module esm_fetch_decode
   import esm_pkg::*;
#(
   parameter int unsigned      Instr_word_size = 32,
   parameter int unsigned      ADDR_W          = 32,
   parameter int unsigned      FQ_DEPTH        = 4,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic                       imem_rsp_valid,
   input  logic [Instr_word_size-1:0] imem_rsp_data,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          flush_pc,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [Instr_word_size-1:0] Instr,
   output logic                       ALUSrc,
   output logic                       RegWrite,
   output logic                       illegal,
   output logic [ADDR_W-1:0]          pc_out
);

   localparam int unsigned CntW   = $clog2(FQ_DEPTH) + 1;
   localparam int unsigned EntryW = ADDR_W + Instr_word_size;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [CntW-1:0]   outstanding_q, outstanding_d;
   logic [CntW-1:0]   drop_q, drop_d;

   logic [CntW-1:0]   fq_count;
   logic              fq_full, fq_empty;
   logic [EntryW-1:0] fq_head;
   logic [CntW:0]     inflight;
   logic              credit, req_fire, rsp_drop, push, pop;
   decode_t           dec;

   assign inflight = {1'b0, fq_count} + {1'b0, outstanding_q};
   assign credit   = (inflight < (CntW + 1)'(FQ_DEPTH));

   assign imem_req_valid = rst && credit && !flush;
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Words already in flight when a flush lands belong to the old path and must not reach ESM.
   assign rsp_drop = imem_rsp_valid && (flush || (drop_q != '0));
   assign push     = imem_rsp_valid && !rsp_drop;
   assign pop      = instr_valid && instr_ready && !flush;

   always_comb begin
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
      if (flush) begin
         pc_d     = flush_pc;
         rsp_pc_d = flush_pc;
         drop_d   = outstanding_q - CntW'(imem_rsp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + ADDR_W'(4);
         if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
         // Responses return in request order, so the next kept word sits at rsp_pc_q.
         if (push) rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   esm_fetch_queue #(
      .Width (EntryW),
      .Depth (FQ_DEPTH)
   ) u_fetch_queue (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (push),
      .push_data_i ({rsp_pc_q, imem_rsp_data}),
      .pop_i       (pop),
      .clear_i     (flush),
      .pop_data_o  (fq_head),
      .full_o      (fq_full),
      .empty_o     (fq_empty),
      .count_o     (fq_count)
   );

   assign instr_valid = rst && !fq_empty;
   assign Instr       = fq_head[Instr_word_size-1:0];
   assign pc_out      = fq_head[EntryW-1:Instr_word_size];

   always_comb begin
      dec      = decode_opcode(fq_head[6:0]);
      ALUSrc   = instr_valid && dec.alu_src;
      RegWrite = instr_valid && dec.reg_write;
      illegal  = instr_valid && dec.illegal;
   end

   rsp_needs_request : assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outstanding_q != '0));

   push_never_overflows : assert property (@(posedge clk) disable iff (!rst)
      !(push && !flush && fq_full && !pop));

endmodule

// File: tb/tb_esm_fetch_decode.sv
// Randomized scoreboard bench for esm_fetch_decode: an in-order memory model feeds the DUT and
// a reference stream of {pc, word, decode} is compared against every word ESM consumes.

module tb_esm_fetch_decode;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        flush;
   logic [31:0] flush_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] Instr;
   logic        ALUSrc, RegWrite, illegal;
   logic [31:0] pc_out;

   esm_fetch_decode #(
      .Instr_word_size (32),
      .ADDR_W          (32),
      .FQ_DEPTH        (4),
      .RESET_PC        (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Instr          (Instr),
      .ALUSrc         (ALUSrc),
      .RegWrite       (RegWrite),
      .illegal        (illegal),
      .pc_out         (pc_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: decode as {ALUSrc, RegWrite, illegal} straight from the opcode table.
   function automatic logic [2:0] ref_decode(input logic [31:0] w);
      case (w[6:0])
         7'b0110011: return 3'b010;
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111: return 3'b110;
         7'b0100011: return 3'b100;
         7'b1100011: return 3'b000;
         7'b1101111: return 3'b010;
         default:    return 3'b001;
      endcase
   endfunction

   logic [31:0] dir_words [5] = '{32'h00500093, 32'h002081B3, 32'h0020A023, 32'h00000063,
                                  32'hFFFFFFFF};
   logic [2:0]  dir_dec   [5] = '{3'b110, 3'b010, 3'b100, 3'b000, 3'b001};
   logic [6:0]  opc_tbl   [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0001111,
                                   7'b1110011, 7'b1111111};
   bit directed = 1'b1;

   // Memory content is a pure function of the address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] h;
      if (directed && a < 32'd20) return dir_words[a[4:2]];
      h = a * 32'h9E3779B1;
      h = h ^ (h >> 15);
      return {h[31:7], opc_tbl[h % 32'd12]};
   endfunction

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [2:0]  dec;
   } exp_t;

   mreq_t       mq[$];
   exp_t        exp_q[$];
   logic [31:0] ref_pc = RESET_PC;
   int          cyc = 0;
   int          last_due = 0;
   int          lat = 1;
   int          p_req_ready = 100;
   int          p_instr_ready = 100;

   // Memory responder and reference stream: drive at negedge, observe handshakes 2 units later.
   initial begin
      mreq_t m;
      int    d;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_req_ready = 1'b0;
      instr_ready    = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         imem_rsp_valid = 1'b0;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(m.addr);
         end
         imem_req_ready = ($urandom_range(99) < p_req_ready);
         instr_ready    = ($urandom_range(99) < p_instr_ready);
         #2;
         if (!rst) begin
            mq.delete();
            exp_q.delete();
            ref_pc   = RESET_PC;
            last_due = 0;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               d = cyc + ((lat == 0) ? int'($urandom_range(1, 3)) : lat);
               if (d <= last_due) d = last_due + 1;
               mq.push_back('{addr: imem_addr, due: d});
               last_due = d;
            end
            if (flush) begin
               exp_q.delete();
               ref_pc = flush_pc;
            end
         end
         while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: ref_pc, instr: word_at(ref_pc), dec: ref_decode(word_at(ref_pc))});
            ref_pc = ref_pc + 32'd4;
         end
      end
   end

   // Monitor: every word ESM takes must be the next one of the reference stream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            if (!instr_valid) begin
               check("gated_decode", 32'({ALUSrc, RegWrite, illegal}), 32'd0);
            end else if (instr_ready && !flush) begin
               if (exp_q.size() == 0) begin
                  check("scoreboard_nonempty", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("pc_out", pc_out, e.pc);
                  check("instr", Instr, e.instr);
                  check("decode", 32'({ALUSrc, RegWrite, illegal}), 32'(e.dec));
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int k, pops, fires;
      bit found;
      rst      = 1'b0;
      flush    = 1'b0;
      flush_pc = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #4;
      check("reset_req_valid", 32'(imem_req_valid), 32'd0);
      check("reset_instr_valid", 32'(instr_valid), 32'd0);

      // Streaming from RESET_PC, latency and throughput, directed decode words
      step();
      rst = 1'b1;
      #3;
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_addr, RESET_PC);
      found = 1'b0;
      k = 0;
      for (int i = 1; i <= 6 && !found; i++) begin
         @(negedge clk);
         #4;
         if (instr_valid) begin
            found = 1'b1;
            k = i;
         end
      end
      check("first_latency", 32'(k), 32'd2);
      pops = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #4;
         end
         if (instr_valid && instr_ready) pops++;
         if (i < 5) begin
            check("dir_pc", pc_out, 32'(4 * i));
            check("dir_instr", Instr, dir_words[i]);
            check("dir_decode", 32'({ALUSrc, RegWrite, illegal}), 32'(dir_dec[i]));
         end
      end
      check("throughput", 32'(pops), 32'd16);

      // Credit limit with ESM stalled
      step();
      rst = 1'b0;
      directed = 1'b0;
      p_instr_ready = 0;
      instr_ready = 1'b0;
      #3;
      step();
      rst = 1'b1;
      #3;
      fires = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #4;
         end
         if (imem_req_valid && imem_req_ready) fires++;
      end
      check("credit_fires", 32'(fires), 32'd4);
      check("credit_req_valid", 32'(imem_req_valid), 32'd0);
      check("credit_instr_valid", 32'(instr_valid), 32'd1);
      step();
      p_instr_ready = 100;
      instr_ready = 1'b1;
      #3;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #4;
         if (imem_req_valid && imem_req_ready) found = 1'b1;
      end
      check("credit_resume", 32'(found), 32'd1);

      // Flush with two requests in flight
      step();
      p_instr_ready = 0;
      instr_ready = 1'b0;
      lat = 3;
      flush = 1'b1;
      flush_pc = 32'h40;
      #3;
      step();
      flush = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (i > 0) step();
         if (mq.size() >= 2) begin
            flush = 1'b1;
            flush_pc = 32'h100;
            found = 1'b1;
         end
      end
      check("flush_inflight_setup", 32'(found), 32'd1);
      #3;
      step();
      flush = 1'b0;
      p_instr_ready = 100;
      instr_ready = 1'b1;
      #3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1'b1;
         else begin
            @(negedge clk);
            #4;
         end
      end
      check("flush_first_pc", found ? pc_out : 32'hDEAD_BEEF, 32'h100);

      // Response and flush on the same edge with credit exhausted and ESM ready
      step();
      lat = 2;
      p_instr_ready = 0;
      instr_ready = 1'b0;
      #3;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (imem_rsp_valid && !imem_req_valid && instr_valid) begin
            flush = 1'b1;
            flush_pc = 32'h100;
            instr_ready = 1'b1;
            found = 1'b1;
         end
         #3;
      end
      check("flush_rsp_setup", 32'(found), 32'd1);
      step();
      flush = 1'b0;
      p_instr_ready = 100;
      instr_ready = 1'b1;
      #3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1'b1;
         else begin
            @(negedge clk);
            #4;
         end
      end
      check("flush_rsp_first_pc", found ? pc_out : 32'hDEAD_BEEF, 32'h100);

      // Address wrap past the top of the space
      step();
      lat = 1;
      flush = 1'b1;
      flush_pc = 32'hFFFF_FFF8;
      #3;
      step();
      flush = 1'b0;
      repeat (12) @(negedge clk);

      // Single-cycle reset mid-burst
      step();
      rst = 1'b0;
      #3;
      step();
      rst = 1'b1;
      #3;
      check("midreset_instr_valid", 32'(instr_valid), 32'd0);
      check("midreset_req_valid", 32'(imem_req_valid), 32'd1);
      check("midreset_addr", imem_addr, RESET_PC);

      // Random traffic with random latency, stalls, flushes and resets
      p_req_ready = 70;
      p_instr_ready = 60;
      lat = 0;
      for (int i = 0; i < 1500; i++) begin
         step();
         flush = ($urandom_range(99) < 2);
         if (flush) flush_pc = 32'($urandom_range(0, 255)) << 2;
         rst = !($urandom_range(999) < 3);
      end
      step();
      flush = 1'b0;
      rst = 1'b1;
      p_req_ready = 100;
      p_instr_ready = 100;
      repeat (30) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
